// File: rtl/posit_align_add_pipe.sv
// Posit align-and-add: order operands, align the smaller one, add or subtract.
// Emits an unnormalised sum with carry and sticky for the normalise stage.
module posit_align_add_pipe #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N),
    parameter int MW = N - ES + 3,
    parameter int LW = ES + RS + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          op_sub,
    input  logic          sign1,
    input  logic          sign2,
    input  logic [RS:0]   regime1,
    input  logic [RS:0]   regime2,
    input  logic [ES-1:0] exp1,
    input  logic [ES-1:0] exp2,
    input  logic [MW-1:0] mant1,
    input  logic [MW-1:0] mant2,
    input  logic          zero1,
    input  logic          zero2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [LW-1:0] out_le,
    output logic [MW:0]   out_mant,
    output logic          out_sticky,
    output logic          out_zero,
    output logic [LW-1:0] out_ediff
);

    typedef struct packed {
        logic          sign_b;
        logic          sign_s;
        logic          zero_b;
        logic          zero_s;
        logic [LW-1:0] le_b;
        logic [LW-1:0] le_s;
        logic [MW-1:0] mant_b;
        logic [MW-1:0] mant_s;
    } ord_t;

    typedef struct packed {
        logic          sign_b;
        logic          sign_s;
        logic          zero_b;
        logic          sticky;
        logic [LW-1:0] le_b;
        logic [LW-1:0] ediff;
        logic [MW-1:0] mant_b;
        logic [MW-1:0] mant_sh;
    } aln_t;

    logic v1, v2, v3;
    logic ready1, ready2, ready3;
    ord_t s1_d, s1_q;
    aln_t s2_d, s2_q;

    assign ready3    = !v3 || out_ready;
    assign ready2    = !v2 || ready3;
    assign ready1    = !v1 || ready2;
    assign in_ready  = ready1;
    assign out_valid = v3;

    logic signed [LW-1:0] le1, le2;
    logic                 eff_sign2;
    logic                 one_big;

    // LE = regime * 2^ES + exp is just the concatenation.
    assign le1       = $signed({regime1, exp1});
    assign le2       = $signed({regime2, exp2});
    assign eff_sign2 = sign2 ^ op_sub;

    always_comb begin
        one_big = 1'b1;
        if (zero2)
            one_big = 1'b1;
        else if (zero1)
            one_big = 1'b0;
        else if (le1 != le2)
            one_big = le1 > le2;
        else
            one_big = mant1 >= mant2;
    end

    always_comb begin
        s1_d = '0;
        if (one_big) begin
            s1_d.sign_b = sign1;
            s1_d.zero_b = zero1;
            s1_d.le_b   = le1;
            s1_d.mant_b = mant1;
            s1_d.sign_s = eff_sign2;
            s1_d.zero_s = zero2;
            s1_d.le_s   = le2;
            s1_d.mant_s = mant2;
        end else begin
            s1_d.sign_b = eff_sign2;
            s1_d.zero_b = zero2;
            s1_d.le_b   = le2;
            s1_d.mant_b = mant2;
            s1_d.sign_s = sign1;
            s1_d.zero_s = zero1;
            s1_d.le_s   = le1;
            s1_d.mant_s = mant1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (ready1) begin
            v1 <= in_valid;
            if (in_valid)
                s1_q <= s1_d;
        end
    end

    logic [LW-1:0] diff;
    logic [MW-1:0] lost_mask;

    // Difference of two signed LW values ordered B >= S fits LW unsigned bits.
    assign diff      = s1_q.le_b - s1_q.le_s;
    assign lost_mask = ~({MW{1'b1}} << diff);

    always_comb begin
        s2_d        = '0;
        s2_d.sign_b = s1_q.sign_b;
        s2_d.sign_s = s1_q.sign_s;
        s2_d.zero_b = s1_q.zero_b;
        s2_d.le_b   = s1_q.le_b;
        s2_d.mant_b = s1_q.mant_b;
        if (s1_q.zero_s) begin
            s2_d.ediff   = '0;
            s2_d.mant_sh = '0;
            s2_d.sticky  = 1'b0;
        end else if (int'(diff) >= MW) begin
            s2_d.ediff   = diff;
            s2_d.mant_sh = '0;
            s2_d.sticky  = |s1_q.mant_s;
        end else begin
            s2_d.ediff   = diff;
            s2_d.mant_sh = s1_q.mant_s >> diff;
            s2_d.sticky  = |(s1_q.mant_s & lost_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2   <= 1'b0;
            s2_q <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1)
                s2_q <= s2_d;
        end
    end

    logic          eff_sub;
    logic [MW:0]   sum;
    logic          zero_res;

    assign eff_sub = s2_q.sign_b ^ s2_q.sign_s;

    // B >= S by construction, so the difference cannot underflow.
    always_comb begin
        if (eff_sub)
            sum = {1'b0, s2_q.mant_b} - {1'b0, s2_q.mant_sh};
        else
            sum = {1'b0, s2_q.mant_b} + {1'b0, s2_q.mant_sh};
    end

    assign zero_res = s2_q.zero_b || (eff_sub && (sum == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            v3         <= 1'b0;
            out_sign   <= 1'b0;
            out_le     <= '0;
            out_mant   <= '0;
            out_sticky <= 1'b0;
            out_zero   <= 1'b0;
            out_ediff  <= '0;
        end else if (ready3) begin
            v3 <= v2;
            if (v2) begin
                out_ediff <= s2_q.ediff;
                if (zero_res) begin
                    out_sign   <= 1'b0;
                    out_le     <= '0;
                    out_mant   <= '0;
                    out_sticky <= 1'b0;
                    out_zero   <= 1'b1;
                end else begin
                    out_sign   <= s2_q.sign_b;
                    out_le     <= s2_q.le_b;
                    out_mant   <= sum;
                    out_sticky <= s2_q.sticky;
                    out_zero   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_align_add_pipe.sv
// Bench for posit_align_add_pipe: directed vectors, backpressure, reset,
// and a randomized stream scored against an integer-arithmetic model.
module tb_posit_align_add_pipe;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = $clog2(N);
    localparam int MW = N - ES + 3;
    localparam int LW = ES + RS + 1;
    localparam int RW = RS + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic          sign1, sign2;
    logic [RS:0]   regime1, regime2;
    logic [ES-1:0] exp1, exp2;
    logic [MW-1:0] mant1, mant2;
    logic          zero1, zero2;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [LW-1:0] out_le;
    logic [MW:0]   out_mant;
    logic          out_sticky;
    logic          out_zero;
    logic [LW-1:0] out_ediff;

    always #5 clk = ~clk;

    posit_align_add_pipe #(.N(N), .ES(ES)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .sign1(sign1), .sign2(sign2),
        .regime1(regime1), .regime2(regime2),
        .exp1(exp1), .exp2(exp2),
        .mant1(mant1), .mant2(mant2),
        .zero1(zero1), .zero2(zero2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_le(out_le), .out_mant(out_mant),
        .out_sticky(out_sticky), .out_zero(out_zero),
        .out_ediff(out_ediff)
    );

    typedef struct {
        bit sub, s1, s2, z1, z2;
        int r1, r2, e1, e2, m1, m2;
    } op_t;

    typedef struct {
        bit sign, sticky, zero;
        int le, mant, ediff;
    } res_t;

    res_t q[$];
    op_t  cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    bit   rand_rdy = 0;

    task automatic check(string tag, longint got, longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Signed-value view: +-mant_B +- (mant_S / 2^ediff), magnitude kept.
    function automatic res_t model(op_t o);
        res_t r;
        int le1, le2, leb, les, mb, ms, sh, val;
        bit sb, ss, zs, one_big;
        r = '{default: 0};
        le1 = o.r1 * (1 << ES) + o.e1;
        le2 = o.r2 * (1 << ES) + o.e2;
        if (o.z1 && o.z2) begin
            r.zero = 1;
            return r;
        end
        if (o.z2) one_big = 1;
        else if (o.z1) one_big = 0;
        else one_big = (le1 > le2) || (le1 == le2 && o.m1 >= o.m2);
        if (one_big) begin
            leb = le1; sb = o.s1; mb = o.m1;
            les = le2; ss = o.s2 ^ o.sub; ms = o.m2; zs = o.z2;
        end else begin
            leb = le2; sb = o.s2 ^ o.sub; mb = o.m2;
            les = le1; ss = o.s1; ms = o.m1; zs = o.z1;
        end
        sh = 0;
        if (!zs) begin
            r.ediff = leb - les;
            if (r.ediff >= MW) begin
                r.sticky = (ms != 0);
            end else begin
                sh = ms / (1 << r.ediff);
                r.sticky = (ms % (1 << r.ediff)) != 0;
            end
        end
        val = (sb ? -mb : mb) + (ss ? -sh : sh);
        if (val == 0 && sb != ss) begin
            r.zero = 1;
            r.sticky = 0;
            return r;
        end
        r.sign = sb;
        r.le = leb;
        r.mant = (val < 0) ? -val : val;
        return r;
    endfunction

    function automatic op_t mk(bit sub, bit s1, int r1, int e1, int m1,
                               bit z1, bit s2, int r2, int e2, int m2,
                               bit z2);
        op_t o;
        o.sub = sub;
        o.s1 = s1; o.r1 = r1; o.e1 = e1; o.m1 = m1; o.z1 = z1;
        o.s2 = s2; o.r2 = r2; o.e2 = e2; o.m2 = m2; o.z2 = z2;
        return o;
    endfunction

    function automatic op_t rnd();
        op_t o;
        o.sub = 1'($urandom_range(1));
        o.s1 = 1'($urandom_range(1));
        o.s2 = 1'($urandom_range(1));
        o.r1 = int'($urandom_range(15)) - 8;
        o.r2 = int'($urandom_range(15)) - 8;
        o.e1 = int'($urandom_range(7));
        o.e2 = int'($urandom_range(7));
        o.m1 = 128 + int'($urandom_range(127));
        o.m2 = 128 + int'($urandom_range(127));
        o.z1 = ($urandom_range(7) == 0);
        o.z2 = ($urandom_range(7) == 0);
        case ($urandom_range(3))
            0: begin o.r2 = o.r1; o.e2 = o.e1; o.m2 = o.m1; end
            1: o.r2 = o.r1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic apply(op_t o);
        cur = o;
        op_sub = o.sub;
        sign1 = o.s1;
        sign2 = o.s2;
        regime1 = RW'(o.r1);
        regime2 = RW'(o.r2);
        exp1 = ES'(o.e1);
        exp2 = ES'(o.e2);
        mant1 = MW'(o.m1);
        mant2 = MW'(o.m2);
        zero1 = o.z1;
        zero2 = o.z2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy)
            out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send(op_t o);
        bit acc;
        acc = 0;
        apply(o);
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++)
            tick();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic directed(string t, op_t o, int le, int ed, int mant,
                            bit st, bit sg, bit z);
        send(o);
        tick();
        tick();
        check({t, "_valid"}, out_valid, 1);
        check({t, "_le"}, $signed(out_le), le);
        check({t, "_ediff"}, out_ediff, ed);
        check({t, "_mant"}, out_mant, mant);
        check({t, "_sticky"}, out_sticky, st);
        check({t, "_sign"}, out_sign, sg);
        check({t, "_zero"}, out_zero, z);
        drain();
    endtask

    initial begin
        op_t bp[5];
        int  start;
        reset = 1;
        in_valid = 0;
        out_ready = 1;
        apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));

        fork
            forever begin
                res_t e;
                @(negedge clk);
                if (reset) begin
                    q.delete();
                end else begin
                    if (in_valid && in_ready)
                        q.push_back(model(cur));
                    if (out_valid) begin
                        if (q.size() == 0) begin
                            check("spurious_out", out_valid, 0);
                        end else if (out_ready) begin
                            e = q.pop_front();
                            n_out++;
                            check("sb_sign", out_sign, e.sign);
                            check("sb_le", $signed(out_le), e.le);
                            check("sb_mant", out_mant, e.mant);
                            check("sb_sticky", out_sticky, e.sticky);
                            check("sb_zero", out_zero, e.zero);
                            check("sb_ediff", out_ediff, e.ediff);
                        end else begin
                            check("hold_mant", out_mant, q[0].mant);
                            check("hold_le", $signed(out_le), q[0].le);
                        end
                    end
                end
            end
        join_none

        repeat (3) tick();
        reset = 0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_mant", out_mant, 0);
        check("rst_out_le", out_le, 0);

        directed("add", mk(0, 0, 2, 3, 'h80, 0, 0, 1, 5, 'hC0, 0),
                 19, 6, 'h083, 0, 0, 0);
        directed("negreg", mk(0, 0, -1, 3, 'hC0, 0, 0, -2, 5, 'hC0, 0),
                 -5, 6, 'h0C3, 0, 0, 0);
        directed("swap", mk(0, 0, -2, 5, 'hC1, 0, 0, 2, 3, 'h80, 0),
                 19, 30, 'h080, 1, 0, 0);
        directed("cancel", mk(1, 0, 1, 2, 'hA5, 0, 0, 1, 2, 'hA5, 0),
                 0, 0, 0, 0, 0, 1);
        directed("zero1", mk(0, 0, 3, 1, 'hFF, 1, 1, 1, 5, 'hC0, 0),
                 13, 0, 'h0C0, 0, 1, 0);

        // Backpressure: three fill the pipe, the fourth must wait.
        for (int i = 0; i < 5; i++) bp[i] = rnd();
        start = n_out;
        out_ready = 0;
        for (int i = 0; i < 3; i++) send(bp[i]);
        apply(bp[3]);
        in_valid = 1;
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
        repeat (3) begin
            tick();
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
        send(bp[3]);
        send(bp[4]);
        drain();
        check("bp_count", n_out - start, 5);

        // Reset with two operations in flight.
        send(rnd());
        send(rnd());
        reset = 1;
        tick();
        reset = 0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_mant", out_mant, 0);
        check("mid_rst_le", out_le, 0);
        check("mid_rst_sign", out_sign, 0);
        check("mid_rst_in_ready", in_ready, 1);
        repeat (6) begin
            tick();
            check("no_stale", out_valid, 0);
        end

        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send(rnd());
            if ($urandom_range(3) == 0) tick();
        end
        drain();
        rand_rdy = 0;
        out_ready = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
